// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam logic [63:0] ADDR_LIMIT_DEFAULT = 64'd1016;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    typedef logic port_idx_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for both requester ports plus the memory-side strobes.
interface dmem_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_write, req1_write;
    logic [63:0] req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready;

    logic        rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_rdata, rsp1_rdata;
    logic        rsp0_err, rsp1_err;
    logic        rsp0_ready, rsp1_ready;

    logic [63:0] mem_address, mem_write_data;
    logic        mem_read, mem_write;
    logic [63:0] mem_read_data;

    modport slave (
        input  req0_valid, req1_valid, req0_write, req1_write,
        input  req0_addr, req1_addr, req0_wdata, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output mem_address, mem_write_data, mem_read, mem_write,
        input  mem_read_data
    );

    modport master (
        output req0_valid, req1_valid, req0_write, req1_write,
        output req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic      valid0,
    input  logic      valid1,
    input  port_idx_t last_grant,
    output port_idx_t grant
);
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1)
            grant = ~last_grant;
        else if (valid1)
            grant = 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one 1 KB doubleword memory, one transaction in flight.
// Latency: strobe one cycle after accept, response the cycle after; requests stall while busy, response held until taken.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [63:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    state_t      state_q;
    port_idx_t   last_q, port_q, grant;
    logic        write_q, err_q;
    logic [63:0] addr_q, wdata_q, rdata_q;

    logic        idle, in_access, rsp_vld, rsp_rdy, accept;
    logic        req_write;
    logic [63:0] req_addr, req_wdata;

    rr_arbiter2 u_rr (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    // Handshake outputs are masked during reset so an aborted cycle never completes a transfer.
    assign idle      = (state_q == IDLE) && !reset;
    assign in_access = (state_q == ACCESS) && !reset;
    assign rsp_vld   = (state_q == RESP) && !reset;

    assign bus.req0_ready = idle && bus.req0_valid && (grant == 1'b0);
    assign bus.req1_ready = idle && bus.req1_valid && (grant == 1'b1);
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign req_write = grant ? bus.req1_write : bus.req0_write;
    assign req_addr  = grant ? bus.req1_addr  : bus.req0_addr;
    assign req_wdata = grant ? bus.req1_wdata : bus.req0_wdata;

    assign bus.mem_read       = in_access && !write_q;
    assign bus.mem_write      = in_access && write_q;
    assign bus.mem_address    = in_access ? addr_q  : 64'd0;
    assign bus.mem_write_data = in_access ? wdata_q : 64'd0;

    assign bus.rsp0_valid = rsp_vld && (port_q == 1'b0);
    assign bus.rsp1_valid = rsp_vld && (port_q == 1'b1);
    assign bus.rsp0_rdata = bus.rsp0_valid ? rdata_q : 64'd0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? rdata_q : 64'd0;
    assign bus.rsp0_err   = bus.rsp0_valid && err_q;
    assign bus.rsp1_err   = bus.rsp1_valid && err_q;
    assign rsp_rdy        = port_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        port_q  <= grant;
                        last_q  <= grant;
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= 64'd0;
                        if (req_addr <= ADDR_LIMIT) begin
                            err_q   <= 1'b0;
                            state_q <= ACCESS;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    rdata_q <= write_q ? 64'd0 : bus.mem_read_data;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_rdy)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam logic [63:0] LIMIT = 64'd1016;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment memory seen by the DUT.
    logic [63:0] mem [0:127];
    assign bus.mem_read_data = mem[bus.mem_address[9:3]];
    always @(posedge clk)
        if (bus.mem_write) mem[bus.mem_address[9:3]] <= bus.mem_write_data;

    // Reference model: expected memory image and the single outstanding transaction.
    logic [63:0] ref_mem [0:127];
    bit          m_busy, m_port, m_write, m_err, m_last;
    int          m_age;
    logic [63:0] m_addr, m_wdata, m_rdata;

    int n_cmp, n_bad;
    bit acc0, acc1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit w, input logic [63:0] a, input logic [63:0] d);
        if (p) begin
            bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
        end
    endtask

    function automatic logic [63:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return LIMIT + 64'($urandom_range(1, 200));
        if (r == 1) return {$urandom, $urandom};
        if (r == 2) return LIMIT;
        return 64'($urandom_range(0, 15)) << 3;
    endfunction

    // One clock: inputs are already driven; check outputs, advance the model, step to edge+1.
    task automatic cycle();
        bit win, e_rdy0, e_rdy1, e_strobe, e_rsp;
        logic [63:0] e_ad, e_wd;
        #2;
        win = 1'b0; e_rdy0 = 1'b0; e_rdy1 = 1'b0;
        if (!m_busy && !reset) begin
            if (bus.req0_valid && bus.req1_valid) win = !m_last;
            else                                  win = bus.req1_valid;
            e_rdy0 = bus.req0_valid && !win;
            e_rdy1 = bus.req1_valid && win;
        end
        e_strobe = m_busy && !reset && !m_err && (m_age == 1);
        e_rsp    = m_busy && !reset && (m_age >= (m_err ? 1 : 2));
        e_ad     = e_strobe ? m_addr  : 64'd0;
        e_wd     = e_strobe ? m_wdata : 64'd0;

        check("req0_ready", 64'(bus.req0_ready), 64'(e_rdy0));
        check("req1_ready", 64'(bus.req1_ready), 64'(e_rdy1));
        check("mem_read",   64'(bus.mem_read),   64'(e_strobe && !m_write));
        check("mem_write",  64'(bus.mem_write),  64'(e_strobe && m_write));
        check("mem_address",    bus.mem_address,    e_ad);
        check("mem_write_data", bus.mem_write_data, e_wd);
        check("rsp0_valid", 64'(bus.rsp0_valid), 64'(e_rsp && !m_port));
        check("rsp1_valid", 64'(bus.rsp1_valid), 64'(e_rsp && m_port));
        check("rsp0_rdata", bus.rsp0_rdata, (e_rsp && !m_port) ? m_rdata : 64'd0);
        check("rsp1_rdata", bus.rsp1_rdata, (e_rsp && m_port)  ? m_rdata : 64'd0);
        check("rsp0_err",   64'(bus.rsp0_err),   64'(e_rsp && !m_port && m_err));
        check("rsp1_err",   64'(bus.rsp1_err),   64'(e_rsp && m_port && m_err));

        acc0 = bus.req0_valid && bus.req0_ready;
        acc1 = bus.req1_valid && bus.req1_ready;

        if (reset) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (!m_busy) begin
            if (e_rdy0 || e_rdy1) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_port  = win;
                m_last  = win;
                m_write = win ? bus.req1_write : bus.req0_write;
                m_addr  = win ? bus.req1_addr  : bus.req0_addr;
                m_wdata = win ? bus.req1_wdata : bus.req0_wdata;
                m_err   = m_addr > LIMIT;
                m_rdata = 64'd0;
            end
        end else begin
            if (m_age == 1 && !m_err) begin
                if (m_write) ref_mem[m_addr[9:3]] = m_wdata;
                else         m_rdata = ref_mem[m_addr[9:3]];
            end
            if (e_rsp && (m_port ? bus.rsp1_ready : bus.rsp0_ready)) m_busy = 1'b0;
            else                                                     m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit p, input int pct, input int wr_pct);
        bit hold;
        hold = p ? (bus.req1_valid && !acc1) : (bus.req0_valid && !acc0);
        if (!hold)
            set_req(p, $urandom_range(0, 99) < pct, $urandom_range(0, 99) < wr_pct,
                    rnd_addr(), {$urandom, $urandom});
    endtask

    task automatic drain(input int n);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (n) cycle();
    endtask

    logic [63:0] old16;

    initial begin
        n_cmp = 0; n_bad = 0;
        acc0 = 1'b0; acc1 = 1'b0;
        m_busy = 1'b0; m_last = 1'b1; m_age = 0;
        m_port = 1'b0; m_write = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Store then load at address 8 on port 0.
        set_req(0, 1, 1, 64'd8, 64'h1122334455667788);
        cycle();
        drain(3);
        check("mem_at_8", mem[1], 64'h1122334455667788);
        set_req(0, 1, 0, 64'd8, 64'd0);
        cycle();
        drain(3);

        // Out-of-range and boundary loads on port 1.
        set_req(1, 1, 0, 64'd1017, 64'd0);
        cycle();
        drain(3);
        set_req(1, 1, 0, 64'd1016, 64'd0);
        cycle();
        drain(3);

        // Both ports hammering loads: grants alternate.
        for (int i = 0; i < 16; i++) begin
            drive_port(0, 100, 0);
            drive_port(1, 100, 0);
            cycle();
        end
        drain(4);

        // Port 0 response back-pressured while port 1 waits.
        set_req(0, 1, 0, 64'd24, 64'd0);
        cycle();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 0, 64'd32, 64'd0);
        bus.rsp0_ready = 1'b0;
        repeat (7) cycle();
        bus.rsp0_ready = 1'b1;
        cycle();
        cycle();
        drain(4);

        // Reset lands on the ACCESS cycle of a store to 16.
        old16 = mem[2];
        set_req(0, 1, 1, 64'd16, ~old16);
        cycle();
        set_req(0, 0, 0, 0, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("mem_at_16", mem[2], old16);
        set_req(0, 1, 0, 64'd40, 64'd0);
        set_req(1, 1, 0, 64'd48, 64'd0);
        cycle();
        drain(6);

        // Random traffic with random response back-pressure and occasional reset.
        for (int i = 0; i < 800; i++) begin
            drive_port(0, 50, 40);
            drive_port(1, 50, 40);
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        drain(6);
        for (int i = 0; i < 128; i++)
            check("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
